pc_sequencer: RTL and testbench

//  Program-counter sequencer driving the address port of program memory (p_size-bit address,

---
 rtl/pc_pkg.sv | 26 ++
 rtl/pc_stack.sv | 59 +++++
 rtl/pc_sequencer.sv | 159 +++++++++++++++
 tb/tb_pc_sequencer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter sequencer.
// Optional interrupt entry is enabled by defining PC_IRQ_EN.
package pc_pkg;

  // Next-PC source selected by the priority encoder each cycle
  typedef enum logic [2:0] {
    PC_HOLD = 3'd0,
    PC_INC  = 3'd1,
    PC_SKIP = 3'd2,
    PC_BR   = 3'd3,
    PC_CALL = 3'd4,
    PC_RET  = 3'd5,
    PC_IRQ  = 3'd6
  } pc_sel_t;

  localparam int unsigned PC_SIZE_DEF     = 6;
  localparam int unsigned STACK_DEPTH_DEF = 4;
  localparam int unsigned RESET_VEC_DEF   = 0;
  localparam int unsigned IRQ_VEC_DEF     = 1;

  // A push into a full stack or a pop from an empty one is a stack fault
  function automatic logic stack_fault(input pc_sel_t sel, input logic full, input logic empty);
    return (((sel == PC_CALL) || (sel == PC_IRQ)) && full) || ((sel == PC_RET) && empty);
  endfunction

endpackage

// File: rtl/pc_stack.sv
// Return-address LIFO. Only the pointer is reset; entry contents persist.
// Push into a full stack and pop from an empty stack are ignored here;
// the parent never asserts push and pop together.
module pc_stack
  import pc_pkg::*;
#(
  parameter int unsigned DEPTH = STACK_DEPTH_DEF,
  parameter int unsigned WIDTH = PC_SIZE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    w_wr_idx;
  logic [PW-1:0]    w_top_idx;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_cnt == CW'(DEPTH));
  assign empty     = (r_cnt == {CW{1'b0}});
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign w_wr_idx  = r_cnt[PW-1:0];
  // Index wraps harmlessly when empty; top is not consumed in that case
  assign w_top_idx = r_cnt[PW-1:0] - {{(PW-1){1'b0}}, 1'b1};
  assign top       = r_mem[w_top_idx];

  // Stack pointer: counts occupied entries, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {CW{1'b0}};
    end else if (w_do_push) begin
      r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
    end else if (w_do_pop) begin
      r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Entry storage: written on accepted push, never reset
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: selects next PC (hold/inc/skip/branch/call/
// return) with a hardware return stack. Define PC_IRQ_EN to add the irq
// input and irq_ack output with single-level interrupt entry.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned p_size      = PC_SIZE_DEF,
  parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEF,
  parameter int unsigned RESET_VEC   = RESET_VEC_DEF,
  parameter int unsigned IRQ_VEC     = IRQ_VEC_DEF
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              stall,
  input  logic              branch,
  input  logic              branch_abs,
  input  logic [p_size-1:0] target,
  input  logic              call,
  input  logic              ret,
  input  logic              skip,
  output logic [p_size-1:0] address,
`ifdef PC_IRQ_EN
  input  logic              irq,
  output logic              irq_ack,
`endif
  output logic              stack_err
);

  localparam logic [p_size-1:0] W_ONE   = {{(p_size-1){1'b0}}, 1'b1};
  localparam logic [p_size-1:0] W_TWO   = {{(p_size-2){1'b0}}, 2'b10};
  localparam logic [p_size-1:0] W_RESET = p_size'(RESET_VEC);
  localparam logic [p_size-1:0] W_IRQV  = p_size'(IRQ_VEC);

  logic [p_size-1:0] r_pc;
  logic              r_stack_err;
  logic              r_in_service;
  logic              r_irq_ack;

  pc_sel_t           w_sel;
  logic [p_size-1:0] w_pc_next;
  logic [p_size-1:0] w_pc_inc;
  logic [p_size-1:0] w_pc_skip;
  logic [p_size-1:0] w_pc_br;
  logic [p_size-1:0] w_stk_top;
  logic [p_size-1:0] w_push_data;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_irq_take;

  // Interrupt is only taken when not already in service
`ifdef PC_IRQ_EN
  assign w_irq_take = irq && !r_in_service;
`else
  assign w_irq_take = 1'b0;
`endif

  // Same-width addition gives mod 2^p_size wrap and sign-extended offsets
  assign w_pc_inc  = r_pc + W_ONE;
  assign w_pc_skip = r_pc + W_TWO;
  assign w_pc_br   = branch_abs ? target : (r_pc + target);

  // Priority encoder: stall > irq > ret > call > branch > skip > increment
  always_comb begin
    w_sel = PC_INC;
    if (stall) begin
      w_sel = PC_HOLD;
    end else if (w_irq_take) begin
      w_sel = PC_IRQ;
    end else if (ret) begin
      w_sel = PC_RET;
    end else if (call) begin
      w_sel = PC_CALL;
    end else if (branch) begin
      w_sel = PC_BR;
    end else if (skip) begin
      w_sel = PC_SKIP;
    end else begin
      w_sel = PC_INC;
    end
  end

  // Next-PC mux and stack controls derived from the selection
  always_comb begin
    w_pc_next   = r_pc;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_push_data = w_pc_inc;
    case (w_sel)
      PC_HOLD: w_pc_next = r_pc;
      PC_INC:  w_pc_next = w_pc_inc;
      PC_SKIP: w_pc_next = w_pc_skip;
      PC_BR:   w_pc_next = w_pc_br;
      PC_CALL: begin
        w_pc_next   = target;
        w_push      = 1'b1;
        w_push_data = w_pc_inc;
      end
      PC_RET: begin
        w_pop = 1'b1;
        if (w_empty) begin
          w_pc_next = w_pc_inc;
        end else begin
          w_pc_next = w_stk_top;
        end
      end
      PC_IRQ: begin
        // Return lands on the interrupted, not-yet-executed instruction
        w_pc_next   = W_IRQV;
        w_push      = 1'b1;
        w_push_data = r_pc;
      end
      default: w_pc_next = r_pc;
    endcase
  end

  pc_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (p_size)
  ) u_stack (
    .clk       (Clock),
    .rst_n     (nReset),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_push_data),
    .top       (w_stk_top),
    .full      (w_full),
    .empty     (w_empty)
  );

  // PC register, sticky stack error, interrupt service flag and ack pulse
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_pc         <= W_RESET;
      r_stack_err  <= 1'b0;
      r_in_service <= 1'b0;
      r_irq_ack    <= 1'b0;
    end else begin
      r_pc        <= w_pc_next;
      r_stack_err <= r_stack_err | stack_fault(w_sel, w_full, w_empty);
      r_irq_ack   <= (w_sel == PC_IRQ);
      if (w_sel == PC_IRQ) begin
        r_in_service <= 1'b1;
      end else if (w_sel == PC_RET) begin
        r_in_service <= 1'b0;
      end else begin
        r_in_service <= r_in_service;
      end
    end
  end

  assign address   = r_pc;
  assign stack_err = r_stack_err;
`ifdef PC_IRQ_EN
  assign irq_ack   = r_irq_ack;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default parameters).
// Interrupt checks are compiled in when PC_IRQ_EN is defined.
module tb_pc_sequencer;

  logic       Clock = 1'b0;
  logic       nReset;
  logic       stall, branch, branch_abs, call, ret, skip;
  logic [5:0] target;
  logic [5:0] address;
  logic       stack_err;
  logic       irq;
  logic       irq_ack;

  int errors = 0;
  int checks = 0;

  pc_sequencer dut (
    .Clock      (Clock),
    .nReset     (nReset),
    .stall      (stall),
    .branch     (branch),
    .branch_abs (branch_abs),
    .target     (target),
    .call       (call),
    .ret        (ret),
    .skip       (skip),
    .address    (address),
`ifdef PC_IRQ_EN
    .irq        (irq),
    .irq_ack    (irq_ack),
`endif
    .stack_err  (stack_err)
  );

`ifndef PC_IRQ_EN
  assign irq_ack = 1'b0;
`endif

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    stall = 1'b0; branch = 1'b0; branch_abs = 1'b0; target = 6'd0;
    call = 1'b0; ret = 1'b0; skip = 1'b0; irq = 1'b0;
  endtask

  // Apply one cycle of requests starting at a negedge; returns at next negedge
  task automatic op(input logic st, input logic br, input logic ba, input logic [5:0] tg,
                    input logic ca, input logic re, input logic sk, input logic iq);
    stall = st; branch = br; branch_abs = ba; target = tg;
    call = ca; ret = re; skip = sk; irq = iq;
    @(negedge Clock);
    idle_inputs();
  endtask

  // Async reset from a negedge, leaving PC held at 0 at a later negedge
  task automatic do_reset(input string tag);
    stall = 1'b1;
    nReset = 1'b0;
    #1;
    chk({tag, "_async_addr"}, {2'b00, address}, 8'd0);
    chk({tag, "_async_err"}, {7'd0, stack_err}, 8'd0);
    @(negedge Clock);
    #2 nReset = 1'b1;
    @(negedge Clock);
    stall = 1'b0;
  endtask

  initial begin
    idle_inputs();
    nReset = 1'b0;
    #3;
    chk("rst_addr", {2'b00, address}, 8'd0);
    chk("rst_err", {7'd0, stack_err}, 8'd0);
    chk("rst_ack", {7'd0, irq_ack}, 8'd0);
    @(negedge Clock);
    chk("rst_hold", {2'b00, address}, 8'd0);
    #2 nReset = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge Clock);
      chk($sformatf("free_inc%0d", i), {2'b00, address}, 8'(i));
    end

    // Asynchronous reset between edges
    do_reset("midreset");
    chk("after_reset_pc", {2'b00, address}, 8'd0);

    // Wrap, skip wrap, relative backward branch
    op(0, 1, 1, 6'd63, 0, 0, 0, 0); chk("br_abs63", {2'b00, address}, 8'd63);
    op(0, 0, 0, 6'd0,  0, 0, 0, 0); chk("inc_wrap", {2'b00, address}, 8'd0);
    op(0, 1, 1, 6'd62, 0, 0, 0, 0); chk("br_abs62", {2'b00, address}, 8'd62);
    op(0, 0, 0, 6'd0,  0, 0, 1, 0); chk("skip_wrap", {2'b00, address}, 8'd0);
    op(0, 1, 1, 6'd5,  0, 0, 0, 0); chk("br_abs5", {2'b00, address}, 8'd5);
    op(0, 1, 0, 6'h3E, 0, 0, 0, 0); chk("br_rel_m2", {2'b00, address}, 8'd3);
    op(0, 1, 0, 6'd4,  0, 0, 0, 0); chk("br_rel_p4", {2'b00, address}, 8'd7);
    op(0, 1, 1, 6'd20, 0, 0, 1, 0); chk("br_over_skip", {2'b00, address}, 8'd20);

    // Call / return
    op(0, 1, 1, 6'd10, 0, 0, 0, 0); chk("br_abs10", {2'b00, address}, 8'd10);
    op(0, 0, 0, 6'd40, 1, 0, 0, 0); chk("call40", {2'b00, address}, 8'd40);
    op(0, 0, 0, 6'd0,  0, 1, 0, 0); chk("ret_11", {2'b00, address}, 8'd11);
    op(0, 0, 0, 6'd20, 1, 0, 0, 0); chk("nest_c1", {2'b00, address}, 8'd20);
    op(0, 0, 0, 6'd30, 1, 0, 0, 0); chk("nest_c2", {2'b00, address}, 8'd30);
    op(0, 0, 0, 6'd40, 1, 0, 0, 0); chk("nest_c3", {2'b00, address}, 8'd40);
    op(0, 0, 0, 6'd50, 1, 0, 0, 0); chk("nest_c4", {2'b00, address}, 8'd50);
    op(0, 0, 0, 6'd0,  0, 1, 0, 0); chk("nest_r1", {2'b00, address}, 8'd41);
    op(0, 0, 0, 6'd0,  0, 1, 0, 0); chk("nest_r2", {2'b00, address}, 8'd31);
    op(0, 0, 0, 6'd0,  0, 1, 0, 0); chk("nest_r3", {2'b00, address}, 8'd21);
    op(0, 0, 0, 6'd0,  0, 1, 0, 0); chk("nest_r4", {2'b00, address}, 8'd12);
    chk("nest_err0", {7'd0, stack_err}, 8'd0);

    // Underflow: ret on empty stack
    op(0, 0, 0, 6'd0, 0, 1, 0, 0); chk("under_pc", {2'b00, address}, 8'd13);
    chk("under_err", {7'd0, stack_err}, 8'd1);
    op(0, 0, 0, 6'd0, 0, 0, 0, 0); chk("err_sticky", {7'd0, stack_err}, 8'd1);
    do_reset("rst2");

    // Overflow: fifth call dropped but jump still taken
    op(0, 0, 0, 6'd20, 1, 0, 0, 0); chk("ovf_c1", {2'b00, address}, 8'd20);
    op(0, 0, 0, 6'd30, 1, 0, 0, 0); chk("ovf_c2", {2'b00, address}, 8'd30);
    op(0, 0, 0, 6'd40, 1, 0, 0, 0); chk("ovf_c3", {2'b00, address}, 8'd40);
    op(0, 0, 0, 6'd50, 1, 0, 0, 0); chk("ovf_c4", {2'b00, address}, 8'd50);
    chk("ovf_err_before", {7'd0, stack_err}, 8'd0);
    op(0, 0, 0, 6'd60, 1, 0, 0, 0); chk("ovf_c5", {2'b00, address}, 8'd60);
    chk("ovf_err", {7'd0, stack_err}, 8'd1);
    op(0, 0, 0, 6'd0, 0, 1, 0, 0); chk("ovf_r1", {2'b00, address}, 8'd41);
    op(0, 0, 0, 6'd0, 0, 1, 0, 0); chk("ovf_r2", {2'b00, address}, 8'd31);
    op(0, 0, 0, 6'd0, 0, 1, 0, 0); chk("ovf_r3", {2'b00, address}, 8'd21);
    op(0, 0, 0, 6'd0, 0, 1, 0, 0); chk("ovf_r4", {2'b00, address}, 8'd1);
    op(0, 0, 0, 6'd0, 0, 1, 0, 0); chk("ovf_r5_empty", {2'b00, address}, 8'd2);
    do_reset("rst3");

    // Stall drops requests; ret beats call
    op(0, 0, 0, 6'd30, 1, 0, 0, 0); chk("st_call30", {2'b00, address}, 8'd30);
    op(1, 1, 1, 6'd50, 1, 0, 0, 0); chk("stall_hold", {2'b00, address}, 8'd30);
    op(0, 0, 0, 6'd0,  0, 0, 0, 0); chk("stall_not_queued", {2'b00, address}, 8'd31);
    op(0, 0, 0, 6'd0,  0, 1, 0, 0); chk("stall_stack_kept", {2'b00, address}, 8'd1);
    chk("stall_err0", {7'd0, stack_err}, 8'd0);
    op(0, 0, 0, 6'd40, 1, 0, 0, 0); chk("rc_call40", {2'b00, address}, 8'd40);
    op(0, 0, 0, 6'd50, 1, 1, 0, 0); chk("rc_ret_wins", {2'b00, address}, 8'd2);
    chk("rc_err0", {7'd0, stack_err}, 8'd0);
    op(0, 0, 0, 6'd0,  0, 1, 0, 0); chk("rc_no_push", {2'b00, address}, 8'd3);
    chk("rc_err1", {7'd0, stack_err}, 8'd1);

`ifdef PC_IRQ_EN
    do_reset("rst4");
    op(0, 1, 1, 6'd20, 0, 0, 0, 0); chk("irq_pc20", {2'b00, address}, 8'd20);
    op(0, 0, 0, 6'd0, 0, 0, 0, 1);
    chk("irq_entry", {2'b00, address}, 8'd1);
    chk("irq_ack1", {7'd0, irq_ack}, 8'd1);
    op(0, 0, 0, 6'd0, 0, 0, 0, 1);
    chk("irq_nested_ign", {2'b00, address}, 8'd2);
    chk("irq_ack0", {7'd0, irq_ack}, 8'd0);
    op(0, 0, 0, 6'd0, 0, 1, 0, 0);
    chk("irq_ret", {2'b00, address}, 8'd20);
    chk("irq_err0", {7'd0, stack_err}, 8'd0);
    op(0, 0, 0, 6'd0, 0, 0, 0, 1);
    chk("irq_reentry", {2'b00, address}, 8'd1);
    chk("irq_ack_again", {7'd0, irq_ack}, 8'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
